// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and dual-port memory bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int DATA = 72,
    parameter int ADDR = 10,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*ADDR-1:0] req_addr;
    logic [NREQ*DATA-1:0] req_din;
    logic [NREQ-1:0]      rsp_valid;
    logic [DATA-1:0]      rsp_data;
    logic [DATA-1:0]      rsp_data_b;
    logic                 a_wr;
    logic [ADDR-1:0]      a_addr;
    logic [DATA-1:0]      a_din;
    logic [DATA-1:0]      a_dout;
    logic                 b_wr;
    logic [ADDR-1:0]      b_addr;
    logic [DATA-1:0]      b_din;
    logic [DATA-1:0]      b_dout;

    modport slave (
        input  req_valid, req_wr, req_addr, req_din, a_dout, b_dout,
        output req_ready, rsp_valid, rsp_data, rsp_data_b,
        output a_wr, a_addr, a_din, b_wr, b_addr, b_din
    );

    modport master (
        output req_valid, req_wr, req_addr, req_din, a_dout, b_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_data_b,
        input  a_wr, a_addr, a_din, b_wr, b_addr, b_din
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-grant arbiter for a dual-port memory (option: MEM_PORT_ARB_COLLISION_EN)
module mem_port_arbiter #(
    parameter int DATA = 72,
    parameter int ADDR = 10,
    parameter int NREQ = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   ptr, ptr_nxt;
    logic            gnt_a, gnt_b;
    logic [IW-1:0]   id_a, id_b;
    logic            wr_a, wr_b;
    logic [ADDR-1:0] addr_a, addr_b;
    logic [DATA-1:0] din_a, din_b;
    logic            pend_a_v, pend_b_v;
    logic [IW-1:0]   pend_a_id, pend_b_id;

    always_comb begin
        int          idx_i;
        logic [IW-1:0] idx;
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        id_a   = '0;
        id_b   = '0;
        wr_a   = 1'b0;
        wr_b   = 1'b0;
        addr_a = '0;
        addr_b = '0;
        din_a  = '0;
        din_b  = '0;
        idx_i  = 0;
        idx    = '0;
        // Scan in rotation order from ptr; first two valid requesters win A then B.
        for (int k = 0; k < NREQ; k++) begin
            idx_i = (int'(ptr) + k) % NREQ;
            idx   = IW'(idx_i);
            if (!rst && bus.req_valid[idx]) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    id_a  = idx;
                end else if (!gnt_b) begin
                    gnt_b = 1'b1;
                    id_b  = idx;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (id_a == IW'(i)) begin
                wr_a   = bus.req_wr[i];
                addr_a = bus.req_addr[i*ADDR +: ADDR];
                din_a  = bus.req_din[i*DATA +: DATA];
            end
            if (id_b == IW'(i)) begin
                wr_b   = bus.req_wr[i];
                addr_b = bus.req_addr[i*ADDR +: ADDR];
                din_b  = bus.req_din[i*DATA +: DATA];
            end
        end
`ifdef MEM_PORT_ARB_COLLISION_EN
        // Hold back B on a same-address hazard; it keeps its turn because ptr only passes A.
        if (gnt_b && (addr_a == addr_b) && (wr_a || wr_b))
            gnt_b = 1'b0;
`endif
    end

    always_comb begin
        ptr_nxt = ptr;
        if (gnt_b)
            ptr_nxt = (id_b == IW'(NREQ - 1)) ? '0 : id_b + 1'b1;
        else if (gnt_a)
            ptr_nxt = (id_a == IW'(NREQ - 1)) ? '0 : id_a + 1'b1;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = (gnt_a && id_a == IW'(i)) || (gnt_b && id_b == IW'(i));
            bus.rsp_valid[i] = (pend_a_v && pend_a_id == IW'(i)) || (pend_b_v && pend_b_id == IW'(i));
        end
        bus.a_wr   = gnt_a && wr_a;
        bus.a_addr = gnt_a ? addr_a : '0;
        bus.a_din  = gnt_a ? din_a  : '0;
        bus.b_wr   = gnt_b && wr_b;
        bus.b_addr = gnt_b ? addr_b : '0;
        bus.b_din  = gnt_b ? din_b  : '0;
        // A lone port B read is steered onto the primary data lane.
        if (pend_a_v)
            bus.rsp_data = bus.a_dout;
        else if (pend_b_v)
            bus.rsp_data = bus.b_dout;
        else
            bus.rsp_data = '0;
        bus.rsp_data_b = (pend_a_v && pend_b_v) ? bus.b_dout : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            pend_a_v  <= 1'b0;
            pend_b_v  <= 1'b0;
            pend_a_id <= '0;
            pend_b_id <= '0;
        end else begin
            ptr       <= ptr_nxt;
            pend_a_v  <= gnt_a && !wr_a;
            pend_b_v  <= gnt_b && !wr_b;
            pend_a_id <= id_a;
            pend_b_id <= id_b;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter against a queue-based model
module tb_mem_port_arbiter;
    localparam int DATA = 72;
    localparam int ADDR = 10;
    localparam int NREQ = 4;
    localparam int MSZ  = 2 ** ADDR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) bus ();

    mem_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA-1:0] mem    [MSZ];
    logic [DATA-1:0] shadow [MSZ];

    // Dual-port read-first memory; port B write lands last so it wins a same-address collision.
    always @(posedge clk) begin
        bus.a_dout <= mem[bus.a_addr];
        bus.b_dout <= mem[bus.b_addr];
        if (bus.a_wr) mem[bus.a_addr] <= bus.a_din;
        if (bus.b_wr) mem[bus.b_addr] <= bus.b_din;
    end

    logic [NREQ-1:0] v, w;
    logic [ADDR-1:0] ad [NREQ];
    logic [DATA-1:0] dn [NREQ];

    int m_ptr;
    logic [NREQ-1:0] e_mask;
    logic [DATA-1:0] e_data, e_data_b;
    logic            e_two;
    logic [NREQ-1:0] obs_rdy, obs_rsp;
    logic [DATA-1:0] obs_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*ADDR +: ADDR] = ad[i];
            bus.req_din[i*DATA +: DATA]  = dn[i];
        end
        bus.req_valid = v;
        bus.req_wr    = w;
    endtask

    task automatic check_cycle();
        int order[$];
        int ga, gb;
        logic [NREQ-1:0] exp_rdy;
        obs_rdy  = bus.req_ready;
        obs_rsp  = bus.rsp_valid;
        obs_data = bus.rsp_data;
        if (rst) begin
            check("rst_ready", bus.req_ready, '0);
            check("rst_rsp_valid", bus.rsp_valid, '0);
            check("rst_a_wr", bus.a_wr, 1'b0);
            check("rst_b_wr", bus.b_wr, 1'b0);
            m_ptr  = 0;
            e_mask = '0;
            e_two  = 1'b0;
            return;
        end
        check("rsp_valid", bus.rsp_valid, e_mask);
        if (e_mask != '0) check("rsp_data", bus.rsp_data, e_data);
        if (e_two) check("rsp_data_b", bus.rsp_data_b, e_data_b);

        for (int k = 0; k < NREQ; k++)
            if (v[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
        ga = (order.size() > 0) ? order[0] : -1;
        gb = (order.size() > 1) ? order[1] : -1;
`ifdef MEM_PORT_ARB_COLLISION_EN
        if (gb >= 0 && ad[gb] == ad[ga] && (w[ga] || w[gb])) gb = -1;
`endif
        exp_rdy = '0;
        if (ga >= 0) exp_rdy[ga] = 1'b1;
        if (gb >= 0) exp_rdy[gb] = 1'b1;
        check("req_ready", bus.req_ready, exp_rdy);
        check("a_wr",   bus.a_wr,   (ga >= 0) ? w[ga]  : 1'b0);
        check("a_addr", bus.a_addr, (ga >= 0) ? ad[ga] : '0);
        check("a_din",  bus.a_din,  (ga >= 0) ? dn[ga] : '0);
        check("b_wr",   bus.b_wr,   (gb >= 0) ? w[gb]  : 1'b0);
        check("b_addr", bus.b_addr, (gb >= 0) ? ad[gb] : '0);
        check("b_din",  bus.b_din,  (gb >= 0) ? dn[gb] : '0);

        e_mask = '0;
        e_two  = 1'b0;
        if (ga >= 0 && !w[ga]) begin
            e_mask[ga] = 1'b1;
            e_data     = shadow[ad[ga]];
        end
        if (gb >= 0 && !w[gb]) begin
            e_mask[gb] = 1'b1;
            if (ga >= 0 && !w[ga]) begin
                e_data_b = shadow[ad[gb]];
                e_two    = 1'b1;
            end else begin
                e_data = shadow[ad[gb]];
            end
        end
        if (ga >= 0 && w[ga]) shadow[ad[ga]] = dn[ga];
        if (gb >= 0 && w[gb]) shadow[ad[gb]] = dn[gb];
        if (gb >= 0)      m_ptr = (gb + 1) % NREQ;
        else if (ga >= 0) m_ptr = (ga + 1) % NREQ;
        if (ga >= 0) v[ga] = 1'b0;
        if (gb >= 0) v[gb] = 1'b0;
    endtask

    task automatic tick();
        apply();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v   = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        v[i]  = 1'b1;
        w[i]  = wr;
        ad[i] = a;
        dn[i] = d;
    endtask

    task automatic drain(input int limit);
        for (int c = 0; c < limit && v != '0; c++) tick();
        check("drain_done", v, '0);
    endtask

    initial begin
        logic [95:0] r96;
        for (int i = 0; i < MSZ; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        v = '0;
        w = '0;
        for (int i = 0; i < NREQ; i++) begin
            ad[i] = '0;
            dn[i] = '0;
        end
        m_ptr = 0; e_mask = '0; e_two = 1'b0; e_data = '0; e_data_b = '0;
        #1;
        do_reset();

        set_req(0, 1'b1, 10'h005, 72'h123);
        tick();
        set_req(2, 1'b0, 10'h005, '0);
        tick();
        check("t1_ready", obs_rdy, 4'b0100);
        tick();
        check("t1_rsp_valid", obs_rsp, 4'b0100);
        check("t1_rsp_data", obs_data, 72'h123);

        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, ADDR'(i + 1), '0);
            tick();
            check("rr_pair", obs_rdy, (c % 2 == 0) ? 4'b0011 : 4'b1100);
        end
        v = '0;
        tick();

        do_reset();
        set_req(1, 1'b1, 10'h010, 72'hAA);
        set_req(3, 1'b1, 10'h010, 72'hBB);
        drain(4);
        set_req(0, 1'b0, 10'h010, '0);
        tick();
        tick();
        check("ww_rsp_data", obs_data, 72'hBB);

        do_reset();
        set_req(0, 1'b1, 10'h007, 72'h11);
        tick();
        do_reset();
        set_req(0, 1'b1, 10'h007, 72'h55);
        set_req(1, 1'b0, 10'h007, '0);
        drain(4);
        tick();
`ifdef MEM_PORT_ARB_COLLISION_EN
        check("rw_rsp_data", obs_data, 72'h55);
`else
        check("rw_rsp_data", obs_data, 72'h11);
`endif

        do_reset();
        set_req(2, 1'b0, 10'h005, '0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDR'(i), 72'h77);
        tick();
        rst = 1'b0;
        v = '0;
        tick();
        check("post_rst_rsp", obs_rsp, 4'b0000);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, ADDR'(i), '0);
        tick();
        check("post_rst_ptr", obs_rdy, 4'b0011);
        v = '0;
        tick();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    r96 = {$urandom(), $urandom(), $urandom()};
                    set_req(i, $urandom_range(0, 1) == 1, ADDR'($urandom_range(0, 7)), r96[DATA-1:0]);
                end
            end
            tick();
        end
        v = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
